sp_array: RTL



---
 rtl/sp_pkg.sv | 38 +++
 rtl/sp_array_if.sv | 53 +++++
 rtl/sp_lane.sv | 48 ++++
 rtl/sp_array.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/sp_pkg.sv
`default_nettype none
// sp_pkg - opcode and state encodings shared by the sp_array slice.
// Rev 1.0
package sp_pkg;

  typedef enum logic [5:0] {
    NOP     = 6'd0,
    ADD     = 6'd1,
    SUB     = 6'd2,
    MUL     = 6'd3,
    MAD     = 6'd4,
    AND     = 6'd5,
    OR      = 6'd6,
    XOR     = 6'd7,
    SHL     = 6'd8,
    SHR     = 6'd9,
    MIN     = 6'd10,
    MAX     = 6'd11,
    SETP_LT = 6'd12,
    SETP_EQ = 6'd13,
    BRA     = 6'd14
  } sp_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sp_state_e;

  localparam logic [2:0] PT_IDX = 3'd7;

  // NOP and every code above BRA leave all lanes disabled.
  function automatic logic op_defined(input logic [5:0] op);
    return (op >= ADD) && (op <= BRA);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sp_array_if.sv
`default_nettype none
// sp_array_if - scheduler/register-file side bundle of the SP array.
// Rev 1.0
interface sp_array_if #(
  parameter int LANES  = 4,
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 9,
  parameter int TCNT_W = 9
);
  localparam int SPW = TCNT_W - $clog2(LANES);

  logic                    clr;
  logic                    ena;
  logic                    start;
  logic [5:0]              opcode;
  logic [2:0]              modifier;
  logic [ADDR_W-1:0]       addr_d;
  logic [2:0]              Sp;
  logic [2:0]              Dp;
  logic                    Si;
  logic [TCNT_W-1:0]       thread_cnt;
  logic                    opnd_valid;
  logic                    opnd_ready;
  logic [LANES*WIDTH-1:0]  rs_a;
  logic [LANES*WIDTH-1:0]  rs_b;
  logic [LANES*WIDTH-1:0]  rs_c;
  logic [LANES-1:0]        pred_in;
  logic [LANES*WIDTH-1:0]  out;
  logic [LANES-1:0]        lane_en;
  logic [ADDR_W-1:0]       des_addr;
  logic [2:0]              des_pre;
  logic [LANES-1:0]        pred_out;
  logic                    outen;
  logic [SPW-1:0]          sp_cnt;
  logic                    ack;
  logic                    set_pc_req;

  modport master (
    output clr, ena, start, opcode, modifier, addr_d, Sp, Dp, Si, thread_cnt,
           opnd_valid, rs_a, rs_b, rs_c, pred_in,
    input  opnd_ready, out, lane_en, des_addr, des_pre, pred_out, outen,
           sp_cnt, ack, set_pc_req
  );

  modport slave (
    input  clr, ena, start, opcode, modifier, addr_d, Sp, Dp, Si, thread_cnt,
           opnd_valid, rs_a, rs_b, rs_c, pred_in,
    output opnd_ready, out, lane_en, des_addr, des_pre, pred_out, outen,
           sp_cnt, ack, set_pc_req
  );

endinterface
`default_nettype wire

// File: rtl/sp_lane.sv
`default_nettype none
// sp_lane - single-lane combinational ALU of the SP array.
// Rev 1.0
module sp_lane
  import sp_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [WIDTH-1:0] i_c,
  input  logic [5:0]       i_op,
  input  logic             i_signed,
  output logic [WIDTH-1:0] o_result,
  output logic             o_pred
);

  localparam int SHW = $clog2(WIDTH);

  logic [SHW-1:0] w_sh;
  logic           w_lt;

  assign w_sh = i_b[SHW-1:0];
  assign w_lt = i_signed ? ($signed(i_a) < $signed(i_b)) : (i_a < i_b);

  always_comb begin
    o_result = '0;
    o_pred   = 1'b0;
    case (i_op)
      ADD:     o_result = i_a + i_b;
      SUB:     o_result = i_a - i_b;
      MUL:     o_result = i_a * i_b;
      MAD:     o_result = (i_a * i_b) + i_c;
      AND:     o_result = i_a & i_b;
      OR:      o_result = i_a | i_b;
      XOR:     o_result = i_a ^ i_b;
      SHL:     o_result = i_a << w_sh;
      SHR:     o_result = i_signed ? $unsigned($signed(i_a) >>> w_sh) : (i_a >> w_sh);
      MIN:     o_result = w_lt ? i_a : i_b;
      MAX:     o_result = w_lt ? i_b : i_a;
      SETP_LT: o_pred   = w_lt;
      SETP_EQ: o_pred   = (i_a == i_b);
      default: o_result = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/sp_array.sv
`default_nettype none
// sp_array - multi-lane SP: sequences one warp instruction over thread_cnt threads.
// Rev 1.0
module sp_array
  import sp_pkg::*;
#(
  parameter int LANES  = 4,
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 9,
  parameter int TCNT_W = 9
) (
  input  logic      clk,
  input  logic      Resetn,
  sp_array_if.slave bus
);

  localparam int LOG2L = $clog2(LANES);
  localparam int SPW   = TCNT_W - LOG2L;
  localparam int TW    = TCNT_W + 1;

  sp_state_e              r_state;
  sp_state_e              w_state_nxt;
  logic [5:0]             r_op;
  logic                   r_signed;
  logic [ADDR_W-1:0]      r_addr;
  logic [2:0]             r_sp;
  logic [2:0]             r_dp;
  logic                   r_si;
  logic [TCNT_W-1:0]      r_tcnt;
  logic [SPW-1:0]         r_beat;
  logic                   r_any_en;

  logic [LANES*WIDTH-1:0] r_out;
  logic [LANES-1:0]       r_lane_en;
  logic [LANES-1:0]       r_pred_out;
  logic [ADDR_W-1:0]      r_des_addr;
  logic [2:0]             r_des_pre;
  logic                   r_outen;
  logic [SPW-1:0]         r_sp_cnt;

  logic                   w_kill;
  logic                   w_issue;
  logic                   w_ready;
  logic                   w_accept;
  logic                   w_ack;
  logic                   w_pcreq;
  logic                   w_last;
  logic                   w_op_ok;
  logic [TW-1:0]          w_base;
  logic [LANES-1:0]       w_en;
  logic [LANES-1:0]       w_pred;
  logic [LANES*WIDTH-1:0] w_out;

  assign w_kill  = !Resetn || bus.clr;
  assign w_issue = (r_state == IDLE) && bus.start && bus.ena;
  assign w_op_ok = op_defined(r_op);
  // First thread index of the current beat; the beat is last once it covers thread_cnt.
  assign w_base  = TW'(r_beat) << LOG2L;
  assign w_last  = (w_base + TW'(LANES)) >= TW'(r_tcnt);

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [TW-1:0]    w_tid;
    logic [WIDTH-1:0] w_res;
    logic             w_lp;

    assign w_tid = w_base + TW'(gi);
    assign w_en[gi] = (w_tid < TW'(r_tcnt)) && w_op_ok &&
                      ((r_sp == PT_IDX) || (bus.pred_in[gi] ^ r_si));

    sp_lane #(.WIDTH(WIDTH)) u_lane (
      .i_a      (bus.rs_a[gi*WIDTH +: WIDTH]),
      .i_b      (bus.rs_b[gi*WIDTH +: WIDTH]),
      .i_c      (bus.rs_c[gi*WIDTH +: WIDTH]),
      .i_op     (r_op),
      .i_signed (r_signed),
      .o_result (w_res),
      .o_pred   (w_lp)
    );

    assign w_out[gi*WIDTH +: WIDTH] = w_en[gi] ? w_res : '0;
    assign w_pred[gi]               = w_en[gi] & w_lp;
  end

  always_ff @(posedge clk) begin
    if (!Resetn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b0;
    w_accept    = 1'b0;
    w_ack       = 1'b0;
    w_pcreq     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_issue) begin
          w_state_nxt = (bus.thread_cnt == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        w_ready  = bus.ena;
        w_accept = bus.ena && bus.opnd_valid;
        if (w_accept && w_last) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        // Leaves DONE even when frozen so ack/set_pc_req stay single-cycle.
        w_ack       = 1'b1;
        w_pcreq     = (r_op == BRA) && r_any_en;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
    if (w_kill) begin
      w_state_nxt = IDLE;
      w_ready     = 1'b0;
      w_accept    = 1'b0;
      w_ack       = 1'b0;
      w_pcreq     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_kill) begin
      r_op       <= '0;
      r_signed   <= 1'b0;
      r_addr     <= '0;
      r_sp       <= '0;
      r_dp       <= '0;
      r_si       <= 1'b0;
      r_tcnt     <= '0;
      r_beat     <= '0;
      r_any_en   <= 1'b0;
      r_out      <= '0;
      r_lane_en  <= '0;
      r_pred_out <= '0;
      r_des_addr <= '0;
      r_des_pre  <= '0;
      r_outen    <= 1'b0;
      r_sp_cnt   <= '0;
    end else begin
      r_outen <= w_accept;
      if (w_issue) begin
        r_op     <= bus.opcode;
        r_signed <= bus.modifier[0];
        r_addr   <= bus.addr_d;
        r_sp     <= bus.Sp;
        r_dp     <= bus.Dp;
        r_si     <= bus.Si;
        r_tcnt   <= bus.thread_cnt;
        r_beat   <= '0;
        r_any_en <= 1'b0;
      end
      if (w_accept) begin
        r_out      <= w_out;
        r_lane_en  <= w_en;
        r_pred_out <= w_pred;
        r_des_addr <= r_addr;
        r_des_pre  <= r_dp;
        r_sp_cnt   <= r_beat;
        r_beat     <= r_beat + 1'b1;
        if (|w_en) begin
          r_any_en <= 1'b1;
        end
      end
    end
  end

  assign bus.opnd_ready = w_ready;
  assign bus.out        = r_out;
  assign bus.lane_en    = r_lane_en;
  assign bus.des_addr   = r_des_addr;
  assign bus.des_pre    = r_des_pre;
  assign bus.pred_out   = r_pred_out;
  assign bus.outen      = r_outen;
  assign bus.sp_cnt     = r_sp_cnt;
  assign bus.ack        = w_ack;
  assign bus.set_pc_req = w_pcreq;

endmodule
`default_nettype wire
